mul_seq_ctrl: RTL and testbench



---
 rtl/mul_seq_ctrl.sv | 114 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequential shift-and-add multiplier controller.
// It drives one external 16-bit adder (add_a/add_b -> add_sum) and issues one
// partial-product addition per RUN cycle to form an unsigned OP_W x OP_W product.
// Operands are taken through a start/in_ready handshake, and the product is
// returned through a result_valid/result_ready handshake.
// Optional build macro MUL_EARLY_TERM_EN: when it is defined, RUN also ends as
// soon as no set multiplier bits remain. The product is the same in both builds;
// only the latency changes.
module mul_seq_ctrl #(
   parameter int OP_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [OP_W-1:0] multiplicand,
   input  logic [OP_W-1:0] multiplier,
   output logic            in_ready,
   output logic            busy,
   output logic            result_valid,
   input  logic            result_ready,
   output logic [15:0]     product,
   output logic [15:0]     add_a,
   output logic [15:0]     add_b,
   input  logic [15:0]     add_sum
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [15:0]       r_acc;
   logic [15:0]       r_mcandSh;
   logic [OP_W-1:0]   r_mplierSh;
   logic [3:0]        r_count;
   logic              w_lastStep;

   // Decide whether the current RUN cycle performs the final partial-product addition.
   always_comb begin
      w_lastStep = (r_count == 4'(OP_W - 1));
`ifdef MUL_EARLY_TERM_EN
      if ((r_mplierSh >> 1) == '0) begin
         w_lastStep = 1'b1;
      end
`endif
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. In DONE, result_ready has priority, so start is never accepted there.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (start) w_nextState = RUN;
         RUN:     if (w_lastStep) w_nextState = DONE;
         DONE:    if (result_ready) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Handshake and adder outputs depend only on registered state, with no path from start or result_ready.
   always_comb begin
      in_ready     = (r_state == IDLE);
      busy         = (r_state == RUN);
      result_valid = (r_state == DONE);
      product      = r_acc;
      add_a        = 16'h0;
      add_b        = 16'h0;
      if (r_state == RUN) begin
         add_a = r_acc;
         add_b = r_mplierSh[0] ? r_mcandSh : 16'h0;
      end
   end

   // Datapath: load the operands on accept, then accumulate and shift once per RUN cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc      <= 16'h0;
         r_mcandSh  <= 16'h0;
         r_mplierSh <= '0;
         r_count    <= 4'h0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_acc      <= 16'h0;
                  r_mcandSh  <= {{(16 - OP_W){1'b0}}, multiplicand};
                  r_mplierSh <= multiplier;
                  r_count    <= 4'h0;
               end
            end
            RUN: begin
               r_acc      <= add_sum;
               r_mcandSh  <= r_mcandSh << 1;
               r_mplierSh <= r_mplierSh >> 1;
               r_count    <= r_count + 4'h1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed, self-checking bench for mul_seq_ctrl with OP_W=8.
// The external ripple adder is modelled here as a plain 16-bit combinational sum.
// The expected latency follows MUL_EARLY_TERM_EN when that macro is defined.
module tb_mul_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  multiplicand;
   logic [7:0]  multiplier;
   logic        in_ready;
   logic        busy;
   logic        result_valid;
   logic        result_ready;
   logic [15:0] product;
   logic [15:0] add_a;
   logic [15:0] add_b;
   logic [15:0] add_sum;

   int checkCount = 0;
   int failCount  = 0;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] prod;
   } vec_t;

   vec_t vecs[10];

   mul_seq_ctrl #(.OP_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .in_ready     (in_ready),
      .busy         (busy),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .product      (product),
      .add_a        (add_a),
      .add_b        (add_b),
      .add_sum      (add_sum)
   );

   // External adder: 16 bits wide, with no carry-out.
   assign add_sum = add_a + add_b;

   // 10 ns free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so that the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Expected number of RUN cycles for multiplier b.
   function automatic int expLatency(input logic [7:0] b);
      int hb;
      hb = 1;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) hb = i + 1;
      end
`ifdef MUL_EARLY_TERM_EN
      return hb;
`else
      return (hb > 0) ? 8 : 8;
`endif
   endfunction

   // Start one multiply, then count the edges after the accept edge until result_valid is seen.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, output int lat);
      @(negedge clk);
      start        = 1'b1;
      multiplicand = a;
      multiplier   = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checkOutput("busyAfterAccept", int'(busy), 1);
      lat = 0;
      while (!result_valid && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   // Hand the result back and confirm the return to IDLE.
   task automatic releaseResult();
      result_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      result_ready = 1'b0;
      checkOutput("inReadyAfterRelease", int'(in_ready), 1);
      checkOutput("validAfterRelease", int'(result_valid), 0);
   endtask

   initial begin
      int lat;
      int strayCount;

      vecs[0] = '{a: 8'd13,  b: 8'd11,  prod: 16'd143};
      vecs[1] = '{a: 8'd255, b: 8'd255, prod: 16'hFE01};
      vecs[2] = '{a: 8'd0,   b: 8'd200, prod: 16'd0};
      vecs[3] = '{a: 8'd200, b: 8'd0,   prod: 16'd0};
      vecs[4] = '{a: 8'd13,  b: 8'd4,   prod: 16'd52};
      vecs[5] = '{a: 8'd1,   b: 8'd1,   prod: 16'd1};
      vecs[6] = '{a: 8'd128, b: 8'd128, prod: 16'd16384};
      vecs[7] = '{a: 8'd170, b: 8'd85,  prod: 16'd14450};
      vecs[8] = '{a: 8'd255, b: 8'd1,   prod: 16'd255};
      vecs[9] = '{a: 8'd1,   b: 8'd255, prod: 16'd255};

      rst_n        = 1'b0;
      start        = 1'b0;
      multiplicand = 8'd0;
      multiplier   = 8'd0;
      result_ready = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rstInReady", int'(in_ready), 1);
      checkOutput("rstBusy", int'(busy), 0);
      checkOutput("rstValid", int'(result_valid), 0);
      checkOutput("rstProduct", int'(product), 0);
      checkOutput("idleAddA", int'(add_a), 0);
      checkOutput("idleAddB", int'(add_b), 0);
      rst_n = 1'b1;

      // Table-driven products and latencies.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, lat);
         checkOutput($sformatf("product[%0d]", i), int'(product), int'(vecs[i].prod));
         checkOutput($sformatf("latency[%0d]", i), lat, expLatency(vecs[i].b));
         checkOutput($sformatf("doneAddA[%0d]", i), int'(add_a), 0);
         releaseResult();
      end

      // Backpressure: DONE holds for five cycles, and a start pulse during DONE is ignored.
      applyStimulus(8'd7, 8'd9, lat);
      checkOutput("bpProduct", int'(product), 63);
      for (int c = 0; c < 5; c++) begin
         if (c == 2) start = 1'b1;
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         checkOutput($sformatf("bpHoldProduct[%0d]", c), int'(product), 63);
         checkOutput($sformatf("bpHoldValid[%0d]", c), int'(result_valid), 1);
         checkOutput($sformatf("bpHoldInReady[%0d]", c), int'(in_ready), 0);
      end
      releaseResult();

      // A start pulse and operand changes during RUN are ignored.
      @(negedge clk);
      start        = 1'b1;
      multiplicand = 8'd5;
      multiplier   = 8'd6;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat   = 0;
      @(posedge clk);
      lat++;
      @(negedge clk);
      start        = 1'b1;
      multiplicand = 8'd3;
      multiplier   = 8'd3;
      @(posedge clk);
      lat++;
      @(negedge clk);
      start        = 1'b0;
      multiplicand = 8'hFF;
      multiplier   = 8'hFF;
      while (!result_valid && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checkOutput("runStartProduct", int'(product), 30);
      checkOutput("runStartLatency", lat, expLatency(8'd6));
      releaseResult();
      strayCount = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (result_valid || busy) strayCount++;
      end
      checkOutput("noSecondResult", strayCount, 0);

      // start and result_ready together in DONE: only the return to IDLE happens.
      applyStimulus(8'd9, 8'd9, lat);
      checkOutput("bothProduct", int'(product), 81);
      start        = 1'b1;
      result_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start        = 1'b0;
      result_ready = 1'b0;
      checkOutput("bothInReady", int'(in_ready), 1);
      checkOutput("bothBusy", int'(busy), 0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("bothStillIdle", int'(in_ready), 1);

      // Reset at RUN cycle 4 discards the partial result.
      start        = 1'b1;
      multiplicand = 8'd100;
      multiplier   = 8'd100;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      checkOutput("midRunBusy", int'(busy), 1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("midRstInReady", int'(in_ready), 1);
      checkOutput("midRstBusy", int'(busy), 0);
      checkOutput("midRstValid", int'(result_valid), 0);
      checkOutput("midRstProduct", int'(product), 0);
      applyStimulus(8'd2, 8'd3, lat);
      checkOutput("postRstProduct", int'(product), 6);
      checkOutput("postRstLatency", lat, expLatency(8'd3));
      releaseResult();

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
